// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared field widths and the buffered writeback entry type
package wb_pkg;

    localparam int ROBID_W  = 7;
    localparam int ECAUSE_W = 5;
    localparam int XLEN     = 32;

    typedef struct packed {
        logic                error;
        logic [ECAUSE_W-1:0] ecause;
        logic [ROBID_W-1:0]  robid;
        logic [XLEN-1:0]     result;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry circular FIFO of writeback entries with synchronous clear
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  wb_entry_t                  push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output wb_entry_t                  head
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty differ only in that bit.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    wb_entry_t   mem_q [DEPTH];
    wb_entry_t   mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = wr_ptr_q - rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter over per-source FIFOs feeding the ROB
// Optional WB_BYPASS_EN: when every FIFO is empty, incoming beats are arbitrated directly.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NSRC-1:0]          src_valid,
    output logic [NSRC-1:0]          src_ready,
    input  logic [NSRC-1:0]          src_error,
    input  logic [NSRC*ECAUSE_W-1:0] src_ecause,
    input  logic [NSRC*ROBID_W-1:0]  src_robid,
    input  logic [NSRC*XLEN-1:0]     src_result,
    input  logic                     rob_flush,
    output logic                     wb_valid,
    output logic                     wb_error,
    output logic [ECAUSE_W-1:0]      wb_ecause,
    output logic [ROBID_W-1:0]       wb_robid,
    output logic [XLEN-1:0]          wb_result
);

    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t       src_entry  [NSRC];
    wb_entry_t       fifo_head  [NSRC];
    logic [CW-1:0]   fifo_count [NSRC];
    logic [NSRC-1:0] fifo_push;
    logic [NSRC-1:0] fifo_pop;
    logic [NSRC-1:0] nonempty;
    logic [NSRC-1:0] beat;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] grant;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    logic            bypass_sel;
    wb_entry_t       winner;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            wb_valid_q, wb_valid_d;
    wb_entry_t       wb_q, wb_d;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign src_entry[i] = '{error:  src_error[i],
                                ecause: src_ecause[ECAUSE_W*i +: ECAUSE_W],
                                robid:  src_robid[ROBID_W*i +: ROBID_W],
                                result: src_result[XLEN*i +: XLEN]};
        assign src_ready[i] = (fifo_count[i] != CW'(DEPTH));
        assign nonempty[i]  = (fifo_count[i] != '0);

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .clear     (rob_flush),
            .push      (fifo_push[i]),
            .push_data (src_entry[i]),
            .pop       (fifo_pop[i]),
            .count     (fifo_count[i]),
            .head      (fifo_head[i])
        );
    end

    assign beat = src_valid & src_ready;

    always_comb begin
`ifdef WB_BYPASS_EN
        bypass_sel = (nonempty == '0);
`else
        bypass_sel = 1'b0;
`endif
        req       = bypass_sel ? beat : nonempty;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        // Scan from rr_ptr upward with wrap; first requester wins.
        for (int k = 0; k < NSRC; k++) begin
            cand = PW'((int'(rr_ptr_q) + k) % NSRC);
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end

        winner    = bypass_sel ? src_entry[grant_idx] : fifo_head[grant_idx];
        fifo_push = beat;
        fifo_pop  = '0;
        if (grant_any) begin
            if (bypass_sel) begin
                fifo_push = beat & ~grant;
            end else begin
                fifo_pop = grant;
            end
        end

        wb_valid_d = grant_any && !rob_flush;
        wb_d       = wb_q;
        rr_ptr_d   = rr_ptr_q;
        if (grant_any && !rob_flush) begin
            wb_d     = winner;
            rr_ptr_d = (grant_idx == PW'(NSRC-1)) ? '0 : grant_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wb_valid_q <= wb_valid_d;
            wb_q       <= wb_d;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_error  = wb_q.error;
    assign wb_ecause = wb_q.ecause;
    assign wb_robid  = wb_q.robid;
    assign wb_result = wb_q.result;

endmodule
